ltl_nexttime_monitor: RTL and testbench
=======================================

# ltl_nexttime_monitor

Runtime checker that evaluates one SystemVerilog `nexttime`-family property attempt at a time against a sampled boolean `a`. It covers `nexttime[n]`, `s_nexttime[n]` and their `always` / `s_eventually` compositions. The block sits downstream of the property front end: the front end resolves the property operator and count, and this block consumes them together with the per-tick sample and end-of-trace indication. It reports pass, fail and dropped-attempt events to the assertion scoreboard.

## Interface
Parameters:
- N_MAX, 8, largest supported nexttime count; `cfg_n` above it is clamped.
- CW, $clog2(N_MAX+1), width of `cfg_n` and the internal tick counter.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset; asynchronous, active-low.
- tick  in  1  property clock tick qualifier; only cycles with tick=1 are property ticks.
- start  in  1  begin an attempt at this tick (honoured only with tick=1).
- cfg_op  in  3  operator, sampled with start: 0 NT, 1 S_NT, 2 NT_ALWAYS, 3 S_NT_ALWAYS, 4 NT_S_EVENTUALLY, 5 S_NT_S_EVENTUALLY; 6 and 7 are invalid.
- cfg_n  in  CW  nexttime count, sampled with start.
- a  in  1  sampled operand.
- eot  in  1  end of trace; no further ticks will occur.
- busy  out  1  attempt in progress.
- pass  out  1  one-cycle pulse, attempt passed.
- fail  out  1  one-cycle pulse, attempt failed.
- drop  out  1  one-cycle pulse, start rejected.
- drop_cnt  out  16  saturating count of dropped starts; present only with LTL_NT_DROP_CNT_EN.

## Operation
- FSM states: IDLE, WAIT, CHECK.
- Reset: state IDLE; counter 0; latched op 0; busy, pass, fail, drop, drop_cnt all 0.
- IDLE, accepted start (tick=1, valid op):
  - Latch op and n = min(cfg_n, N_MAX).
  - n=0: evaluate `a` at this same tick, as in the target rule.
  - n>0: go to WAIT with cnt=n.
- WAIT: on each tick, cnt decrements. The tick with cnt==1 is the target tick, where `a` is evaluated:
  - NT / S_NT: a=1 gives pass, a=0 gives fail; return to IDLE.
  - ALWAYS ops: a=0 gives fail and IDLE; otherwise go to CHECK.
  - S_EVENTUALLY ops: a=1 gives pass and IDLE; otherwise go to CHECK.
- CHECK, on each tick:
  - ALWAYS ops: a=0 gives fail and IDLE.
  - S_EVENTUALLY ops: a=1 gives pass and IDLE.
- Non-tick cycles: no state, counter or output change except eot handling.
- eot resolves any open attempt, then the FSM goes to IDLE:
  - WAIT: weak ops (NT, NT_ALWAYS, NT_S_EVENTUALLY) pass; strong ops (S_NT*) fail.
  - CHECK: ALWAYS ops pass; S_EVENTUALLY ops fail.
  - IDLE: no effect.
- eot and tick in the same cycle: the tick is processed first; eot then resolves only an attempt still open. Exactly one of pass/fail is produced per attempt.
- Drop conditions (tick=1 and start=1):
  - Busy at the start of the cycle, even if the attempt concludes on that tick. No back-to-back restart on a concluding tick.
  - cfg_op of 6 or 7 in any state.
- A drop leaves the current attempt untouched. start with eot in IDLE counts as a drop.

## Timing
- Sampling: all inputs sampled on the rising edge of clk. pass, fail, drop and busy are registered.
- Result latency: a decision taken at edge k is visible during cycle k+1 as a one-cycle pulse.
- busy: high from the cycle after an accepted start until the cycle after resolution. busy is never high for an n=0 NT/S_NT attempt; only pass or fail pulses.
- drop_cnt: increments in the same cycle drop is asserted; saturates at 16'hFFFF.
- Async reset mid-attempt: state and outputs are cleared immediately; no pass or fail is emitted for the aborted attempt.

## Configuration
- LTL_NT_DROP_CNT_EN defined: the drop_cnt port and its 16-bit saturating counter are built.
- Undefined: no drop_cnt port and no counter; the drop pulse is unchanged.

## Structure
- Shared package ltl_nt_pkg holds:
  - op_e enum (encodings above), state_e enum.
  - Helpers is_strong(op), is_always(op), is_eventually(op).
- One sub-module, ltl_nt_sat_cnt: parameterised saturating counter used for drop_cnt, instantiated only under the macro.

## Test plan
- NT, n=2: start at tick 0; ticks 1 and 2; a=1 at tick 2 -> pass one cycle after the tick-2 edge. Repeat with a=0 -> fail.
- S_NT, n=3: start; one tick; then eot -> fail. Same sequence with NT -> pass.
- S_NT_ALWAYS, n=1: a=1 for ticks 1..5; a=0 at tick 6 -> fail after tick 6. A variant with eot at tick 5 -> pass.
- S_NT_S_EVENTUALLY, n=1: a=0 on ticks 1..4; tick 5 with a=1 and eot together -> pass (tick processed first). Without a=1 -> fail at eot.
- Busy with NT, n=4: start again at tick 2 -> drop pulse, drop_cnt=1, original attempt still resolves at tick 4. cfg_op=7 -> drop.
- tick held low between ticks -> counter holds. rst_n asserted in WAIT -> busy=0 immediately, no pass/fail. n=0 NT with a=1 -> pass next cycle, busy stays 0.

Source files
------------

// File: rtl/ltl_nt_pkg.sv
// Shared types and operator classification helpers for the nexttime monitor.
package ltl_nt_pkg;

   typedef enum logic [2:0] {
      OP_NT                = 3'd0,
      OP_S_NT              = 3'd1,
      OP_NT_ALWAYS         = 3'd2,
      OP_S_NT_ALWAYS       = 3'd3,
      OP_NT_S_EVENTUALLY   = 3'd4,
      OP_S_NT_S_EVENTUALLY = 3'd5
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_CHECK = 2'd2
   } state_e;

   // Encodings 6 and 7 carry no operator.
   function automatic logic is_valid_op(input logic [2:0] op);
      return op <= 3'd5;
   endfunction

   // Strong forms demand the target tick actually occurs.
   function automatic logic is_strong(input op_e op);
      return (op == OP_S_NT) || (op == OP_S_NT_ALWAYS) || (op == OP_S_NT_S_EVENTUALLY);
   endfunction

   function automatic logic is_always(input op_e op);
      return (op == OP_NT_ALWAYS) || (op == OP_S_NT_ALWAYS);
   endfunction

   function automatic logic is_eventually(input op_e op);
      return (op == OP_NT_S_EVENTUALLY) || (op == OP_S_NT_S_EVENTUALLY);
   endfunction

endpackage

// File: rtl/ltl_nt_sat_cnt.sv
// Saturating up-counter; holds at all-ones.
module ltl_nt_sat_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   // Count increments, stopping at the maximum value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/ltl_nexttime_monitor.sv
// Runtime checker for nexttime / s_nexttime and their always / s_eventually
// compositions, one attempt at a time.
// Optional: define LTL_NT_DROP_CNT_EN to build the drop_cnt port and counter.
module ltl_nexttime_monitor
   import ltl_nt_pkg::*;
#(
   parameter int unsigned N_MAX = 8,
   parameter int unsigned CW    = $clog2(N_MAX + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          tick,
   input  logic          start,
   input  logic [2:0]    cfg_op,
   input  logic [CW-1:0] cfg_n,
   input  logic          a,
   input  logic          eot,
   output logic          busy,
   output logic          pass,
   output logic          fail,
   output logic          drop
`ifdef LTL_NT_DROP_CNT_EN
   ,output logic [15:0]  drop_cnt
`endif
);

   state_e        state, state_d;
   op_e           op_q, op_d;
   logic [CW-1:0] cnt, cnt_d;
   logic          pass_d, fail_d, drop_d, busy_d;
   logic [CW-1:0] n_clamped;
   logic          accept;
   logic          eval;
   op_e           eval_op;

   assign n_clamped = (cfg_n > CW'(N_MAX)) ? CW'(N_MAX) : cfg_n;

   // A start at eot in IDLE cannot see any tick, so it is rejected like the others.
   assign accept = tick && start && (state == ST_IDLE) && is_valid_op(cfg_op) && !eot;

   // Next-state and result decision: the tick is processed first, then eot
   // resolves whatever attempt is still open after that tick.
   always_comb begin
      state_d = state;
      op_d    = op_q;
      cnt_d   = cnt;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      drop_d  = tick && start && !accept;
      eval    = 1'b0;
      eval_op = op_q;

      if (tick) begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_d = op_e'(cfg_op);
                  if (n_clamped == '0) begin
                     eval    = 1'b1;
                     eval_op = op_e'(cfg_op);
                  end else begin
                     state_d = ST_WAIT;
                     cnt_d   = n_clamped;
                  end
               end
            end
            ST_WAIT: begin
               cnt_d = cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  eval = 1'b1;
               end
            end
            ST_CHECK: begin
               if (is_always(op_q) && !a) begin
                  fail_d  = 1'b1;
                  state_d = ST_IDLE;
               end else if (is_eventually(op_q) && a) begin
                  pass_d  = 1'b1;
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end

      // Target-tick rule, shared by n=0 starts and the last WAIT tick.
      if (eval) begin
         if (is_always(eval_op)) begin
            if (a) begin
               state_d = ST_CHECK;
            end else begin
               fail_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end else if (is_eventually(eval_op)) begin
            if (a) begin
               pass_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               state_d = ST_CHECK;
            end
         end else begin
            pass_d  = a;
            fail_d  = !a;
            state_d = ST_IDLE;
         end
      end

      if (eot) begin
         case (state_d)
            ST_WAIT: begin
               pass_d  = !is_strong(op_d);
               fail_d  = is_strong(op_d);
               state_d = ST_IDLE;
            end
            ST_CHECK: begin
               pass_d  = is_always(op_d);
               fail_d  = !is_always(op_d);
               state_d = ST_IDLE;
            end
            default: ;
         endcase
      end

      busy_d = (state_d != ST_IDLE);
   end

   // State, counter, latched operator and registered result pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         op_q  <= OP_NT;
         cnt   <= '0;
         busy  <= 1'b0;
         pass  <= 1'b0;
         fail  <= 1'b0;
         drop  <= 1'b0;
      end else begin
         state <= state_d;
         op_q  <= op_d;
         cnt   <= cnt_d;
         busy  <= busy_d;
         pass  <= pass_d;
         fail  <= fail_d;
         drop  <= drop_d;
      end
   end

`ifdef LTL_NT_DROP_CNT_EN
   ltl_nt_sat_cnt #(
      .W(16)
   ) u_drop_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (drop_d),
      .count (drop_cnt)
   );
`endif

endmodule

// File: tb/tb_ltl_nexttime_monitor.sv
// Directed self-checking bench for ltl_nexttime_monitor.
// Expected vectors are {busy, pass, fail, drop} sampled 1 ns after each edge.
// drop_cnt checks are built only with LTL_NT_DROP_CNT_EN.
module tb_ltl_nexttime_monitor;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic       start = 1'b0;
   logic [2:0] cfg_op = 3'd0;
   logic [3:0] cfg_n = 4'd0;
   logic       a = 1'b0;
   logic       eot = 1'b0;
   logic       busy, pass, fail, drop;
`ifdef LTL_NT_DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   ltl_nexttime_monitor #(
      .N_MAX(8)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .tick   (tick),
      .start  (start),
      .cfg_op (cfg_op),
      .cfg_n  (cfg_n),
      .a      (a),
      .eot    (eot),
      .busy   (busy),
      .pass   (pass),
      .fail   (fail),
      .drop   (drop)
`ifdef LTL_NT_DROP_CNT_EN
      ,.drop_cnt (drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: apply inputs, wait for the edge, compare {busy,pass,fail,drop}.
   task automatic cyc(input string tag, input logic t, input logic s, input logic [2:0] op,
                      input logic [3:0] n, input logic av, input logic e, input logic [3:0] exp);
      tick = t; start = s; cfg_op = op; cfg_n = n; a = av; eot = e;
      @(posedge clk);
      #1;
      check(tag, {28'd0, busy, pass, fail, drop}, {28'd0, exp});
      tick = 1'b0; start = 1'b0; eot = 1'b0; a = 1'b0;
   endtask

   task automatic check_cnt(input string tag, input logic [15:0] exp);
`ifdef LTL_NT_DROP_CNT_EN
      check(tag, {16'd0, drop_cnt}, {16'd0, exp});
`else
      if (exp == 16'hFFFF) $display("unreachable %s", tag);
`endif
   endtask

   initial begin
      #2;
      check("reset_out", {28'd0, busy, pass, fail, drop}, 32'd0);
      check_cnt("reset_cnt", 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // NT n=2, pass then fail
      cyc("nt_pass_s",  1, 1, 3'd0, 4'd2, 0, 0, 4'b1000);
      cyc("nt_pass_t1", 1, 0, 3'd0, 4'd0, 0, 0, 4'b1000);
      cyc("nt_pass_t2", 1, 0, 3'd0, 4'd0, 1, 0, 4'b0100);
      cyc("nt_pass_q",  0, 0, 3'd0, 4'd0, 0, 0, 4'b0000);
      cyc("nt_fail_s",  1, 1, 3'd0, 4'd2, 1, 0, 4'b1000);
      cyc("nt_fail_t1", 1, 0, 3'd0, 4'd0, 1, 0, 4'b1000);
      cyc("nt_fail_t2", 1, 0, 3'd0, 4'd0, 0, 0, 4'b0010);

      // S_NT / NT n=3 cut short by eot
      cyc("snt_eot_s",  1, 1, 3'd1, 4'd3, 0, 0, 4'b1000);
      cyc("snt_eot_t1", 1, 0, 3'd0, 4'd0, 0, 0, 4'b1000);
      cyc("snt_eot",    0, 0, 3'd0, 4'd0, 0, 1, 4'b0010);
      cyc("nt_eot_s",   1, 1, 3'd0, 4'd3, 0, 0, 4'b1000);
      cyc("nt_eot_t1",  1, 0, 3'd0, 4'd0, 0, 0, 4'b1000);
      cyc("nt_eot",     0, 0, 3'd0, 4'd0, 0, 1, 4'b0100);

      // S_NT_ALWAYS n=1: a high ticks 1..5, low at 6
      cyc("sal_s", 1, 1, 3'd3, 4'd1, 0, 0, 4'b1000);
      for (int i = 1; i <= 5; i++) cyc("sal_hold", 1, 0, 3'd0, 4'd0, 1, 0, 4'b1000);
      cyc("sal_fail", 1, 0, 3'd0, 4'd0, 0, 0, 4'b0010);
      // variant: eot together with tick 5
      cyc("sal2_s", 1, 1, 3'd3, 4'd1, 0, 0, 4'b1000);
      for (int i = 1; i <= 4; i++) cyc("sal2_hold", 1, 0, 3'd0, 4'd0, 1, 0, 4'b1000);
      cyc("sal2_eot", 1, 0, 3'd0, 4'd0, 1, 1, 4'b0100);

      // S_NT_S_EVENTUALLY n=1
      cyc("sev_s", 1, 1, 3'd5, 4'd1, 0, 0, 4'b1000);
      for (int i = 1; i <= 4; i++) cyc("sev_wait", 1, 0, 3'd0, 4'd0, 0, 0, 4'b1000);
      cyc("sev_pass_eot", 1, 0, 3'd0, 4'd0, 1, 1, 4'b0100);
      cyc("sev2_s", 1, 1, 3'd5, 4'd1, 0, 0, 4'b1000);
      for (int i = 1; i <= 4; i++) cyc("sev2_wait", 1, 0, 3'd0, 4'd0, 0, 0, 4'b1000);
      cyc("sev2_fail_eot", 1, 0, 3'd0, 4'd0, 0, 1, 4'b0010);

      // Busy drop, NT n=4
      cyc("bd_s",    1, 1, 3'd0, 4'd4, 0, 0, 4'b1000);
      cyc("bd_t1",   1, 0, 3'd0, 4'd0, 0, 0, 4'b1000);
      cyc("bd_drop", 1, 1, 3'd1, 4'd1, 0, 0, 4'b1001);
      check_cnt("bd_cnt1", 16'd1);
      cyc("bd_t3",   1, 0, 3'd0, 4'd0, 0, 0, 4'b1000);
      cyc("bd_t4",   1, 0, 3'd0, 4'd0, 1, 0, 4'b0100);
      cyc("bad_op",  1, 1, 3'd7, 4'd1, 0, 0, 4'b0001);
      cyc("bad_op_q", 1, 0, 3'd0, 4'd0, 1, 0, 4'b0000);
      check_cnt("bad_op_cnt", 16'd2);
      // start on the concluding tick is dropped, no restart
      cyc("cc_s",    1, 1, 3'd0, 4'd1, 0, 0, 4'b1000);
      cyc("cc_drop", 1, 1, 3'd0, 4'd1, 1, 0, 4'b0101);
      cyc("cc_q",    1, 0, 3'd0, 4'd0, 0, 0, 4'b0000);
      // start with eot in IDLE
      cyc("eot_start", 1, 1, 3'd0, 4'd1, 1, 1, 4'b0001);
      check_cnt("eot_start_cnt", 16'd3);

      // tick held low: counter holds
      cyc("th_s",  1, 1, 3'd0, 4'd2, 0, 0, 4'b1000);
      for (int i = 0; i < 3; i++) cyc("th_idle", 0, 0, 3'd0, 4'd0, 1, 0, 4'b1000);
      cyc("th_t1", 1, 0, 3'd0, 4'd0, 0, 0, 4'b1000);
      cyc("th_idle2", 0, 0, 3'd0, 4'd0, 1, 0, 4'b1000);
      cyc("th_t2", 1, 0, 3'd0, 4'd0, 1, 0, 4'b0100);

      // cfg_n above N_MAX clamps to 8
      cyc("cl_s", 1, 1, 3'd1, 4'd15, 0, 0, 4'b1000);
      for (int i = 1; i <= 7; i++) cyc("cl_wait", 1, 0, 3'd0, 4'd0, 0, 0, 4'b1000);
      cyc("cl_target", 1, 0, 3'd0, 4'd0, 1, 0, 4'b0100);

      // n=0 attempts
      cyc("n0_nt",   1, 1, 3'd0, 4'd0, 1, 0, 4'b0100);
      cyc("n0_q",    0, 0, 3'd0, 4'd0, 0, 0, 4'b0000);
      cyc("n0_snt",  1, 1, 3'd1, 4'd0, 0, 0, 4'b0010);
      cyc("n0_al",   1, 1, 3'd2, 4'd0, 1, 0, 4'b1000);
      cyc("n0_al_eot", 0, 0, 3'd0, 4'd0, 0, 1, 4'b0100);

      // async reset in WAIT
      cyc("rs_s",  1, 1, 3'd0, 4'd3, 0, 0, 4'b1000);
      cyc("rs_t1", 1, 0, 3'd0, 4'd0, 0, 0, 4'b1000);
      rst_n = 1'b0;
      #1;
      check("rs_now", {28'd0, busy, pass, fail, drop}, 32'd0);
      check_cnt("rs_cnt", 16'd0);
      cyc("rs_hold", 1, 0, 3'd0, 4'd0, 1, 0, 4'b0000);
      rst_n = 1'b1;
      cyc("rs_after1", 1, 0, 3'd0, 4'd0, 1, 0, 4'b0000);
      cyc("rs_after2", 1, 0, 3'd0, 4'd0, 1, 1, 4'b0000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
